// File: rtl/spi_reg_ctrl_pkg.sv
// Shared types and constants for the SPI register-access sequencer.
package spi_reg_pkg;

  typedef enum logic [1:0] {
    S_CMD   = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2
  } spi_reg_state_t;

  localparam int          CMD_RD_BIT = 7;
  localparam logic [5:0]  STATUS_SIG = 6'b101000;
  localparam logic [7:0]  TX_FILL_RD = 8'hFF;
  localparam logic [7:0]  TX_FILL_WR = 8'h00;

  function automatic logic [7:0] status_byte(input logic wr_drop, input logic rd_under);
    return {STATUS_SIG, wr_drop, rd_under};
  endfunction

endpackage

// File: rtl/spi_reg_ctrl_if.sv
// Register bus with req/ack handshake between the sequencer and the register file.
interface spi_reg_ctrl_if;
  logic       reg_req;
  logic       reg_we;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_ack;
  logic [7:0] reg_rdata;

  modport master (output reg_req, reg_we, reg_addr, reg_wdata, input reg_ack, reg_rdata);
  modport slave  (input reg_req, reg_we, reg_addr, reg_wdata, output reg_ack, reg_rdata);
endinterface

// File: rtl/spi_reg_ctrl_req.sv
// Request holder: latches one access on an issue pulse and keeps it on the bus until ack.
module spi_reg_req (
  input  logic           clk,
  input  logic           rst,
  input  logic           issue,
  input  logic           issue_we,
  input  logic [6:0]     issue_addr,
  input  logic [7:0]     issue_wdata,
  output logic           done,
  spi_reg_ctrl_if.master bus
);

  assign done = bus.reg_req & bus.reg_ack;

  // Request/attribute registers; attributes only change when a new access is issued.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.reg_req   <= 1'b0;
      bus.reg_we    <= 1'b0;
      bus.reg_addr  <= 7'd0;
      bus.reg_wdata <= 8'd0;
    end else if (issue) begin
      bus.reg_req   <= 1'b1;
      bus.reg_we    <= issue_we;
      bus.reg_addr  <= issue_addr;
      bus.reg_wdata <= issue_wdata;
    end else if (done) begin
      bus.reg_req   <= 1'b0;
    end
  end

endmodule

// File: rtl/spi_reg_ctrl.sv
// Command decoder and byte streamer between an SPI byte slave and a req/ack register bus.
module spi_reg_ctrl
  import spi_reg_pkg::*;
#(
  parameter bit AUTO_INC = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           spi_ss,
  input  logic           rx,
  input  logic [7:0]     rx_data,
  input  logic           tx,
  output logic [7:0]     tx_data,
  output logic           err,
  spi_reg_ctrl_if.master bus
);

  spi_reg_state_t state_r, state_s;
  logic [6:0] addr_r, addr_s, issue_addr_s;
  logic [7:0] tx_data_s, issue_wdata_s;
  logic       rd_valid_r, rd_valid_s, rd_pend_r, rd_pend_s, stale_r, stale_s;
  logic       wr_drop_r, wr_drop_s, rd_under_r, rd_under_s;
  logic       issue_s, issue_we_s, rd_need_s, absorb_s, done_s;

  spi_reg_req u_req (
    .clk         (clk),
    .rst         (rst),
    .issue       (issue_s),
    .issue_we    (issue_we_s),
    .issue_addr  (issue_addr_s),
    .issue_wdata (issue_wdata_s),
    .done        (done_s),
    .bus         (bus)
  );

  // Next-state, flag and issue logic; acks of requests left over from a deselect are absorbed.
  always_comb begin
    state_s       = state_r;
    addr_s        = addr_r;
    rd_valid_s    = rd_valid_r;
    rd_pend_s     = rd_pend_r;
    wr_drop_s     = wr_drop_r;
    rd_under_s    = rd_under_r;
    rd_need_s     = 1'b0;
    issue_s       = 1'b0;
    issue_we_s    = 1'b0;
    issue_addr_s  = addr_r;
    issue_wdata_s = rx_data;
    absorb_s      = spi_ss | stale_r;
    stale_s       = done_s ? 1'b0 : (stale_r | (spi_ss & bus.reg_req));

    if (done_s && !absorb_s) begin
      addr_s     = AUTO_INC ? (addr_r + 7'd1) : addr_r;
      rd_valid_s = (state_r == S_READ);
    end else begin
      addr_s     = addr_r;
    end

    if (spi_ss) begin
      state_s    = S_CMD;
      rd_valid_s = 1'b0;
      rd_pend_s  = 1'b0;
    end else begin
      case (state_r)
        S_CMD: begin
          if (tx) begin
            wr_drop_s  = 1'b0;
            rd_under_s = 1'b0;
          end else begin
            wr_drop_s  = wr_drop_r;
          end
          if (rx) begin
            addr_s       = rx_data[6:0];
            issue_addr_s = rx_data[6:0];
            rd_need_s    = rx_data[CMD_RD_BIT];
            state_s      = rx_data[CMD_RD_BIT] ? S_READ : S_WRITE;
          end else begin
            state_s      = S_CMD;
          end
        end
        S_WRITE: begin
          if (rx && bus.reg_req) begin
            wr_drop_s  = 1'b1;
          end else if (rx) begin
            issue_s    = 1'b1;
            issue_we_s = 1'b1;
          end else begin
            issue_s    = 1'b0;
          end
        end
        S_READ: begin
          rd_need_s = rd_pend_r;
          if (tx && rd_valid_r) begin
            rd_valid_s = 1'b0;
            rd_need_s  = 1'b1;
          end else if (tx) begin
            rd_under_s = 1'b1;
          end else begin
            rd_valid_s = rd_valid_s;
          end
        end
        default: state_s = S_CMD;
      endcase
    end

    // A read that finds the bus still busy waits in rd_pend until the holder frees up.
    if (rd_need_s && !bus.reg_req) begin
      issue_s   = 1'b1;
      rd_pend_s = 1'b0;
    end else if (rd_need_s) begin
      rd_pend_s = 1'b1;
    end else begin
      rd_pend_s = rd_pend_s;
    end

    case (state_s)
      S_CMD:   tx_data_s = status_byte(wr_drop_s, rd_under_s);
      S_WRITE: tx_data_s = TX_FILL_WR;
      S_READ: begin
        if (!rd_valid_s) begin
          tx_data_s = TX_FILL_RD;
        end else if (done_s && !absorb_s) begin
          tx_data_s = bus.reg_rdata;
        end else begin
          tx_data_s = tx_data;
        end
      end
      default: tx_data_s = status_byte(wr_drop_s, rd_under_s);
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= S_CMD;
      addr_r     <= 7'd0;
      rd_valid_r <= 1'b0;
      rd_pend_r  <= 1'b0;
      stale_r    <= 1'b0;
      wr_drop_r  <= 1'b0;
      rd_under_r <= 1'b0;
      tx_data    <= 8'hA0;
      err        <= 1'b0;
    end else begin
      state_r    <= state_s;
      addr_r     <= addr_s;
      rd_valid_r <= rd_valid_s;
      rd_pend_r  <= rd_pend_s;
      stale_r    <= stale_s;
      wr_drop_r  <= wr_drop_s;
      rd_under_r <= rd_under_s;
      tx_data    <= tx_data_s;
      err        <= wr_drop_r | rd_under_r;
    end
  end

endmodule
